// File: rtl/debug_controller_if.sv
// Signal bundle between debug_controller, the UART byte-link wrappers and the pipeline top.
// The slave modport is the controller's view; the master modport is the environment's view.
interface debug_controller_if #(
    parameter int NB_DATA     = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int NB_BYTE     = 8
);
    logic [NB_BYTE-1:0]     i_rx_data;
    logic                   i_rx_valid;
    logic [NB_BYTE-1:0]     o_tx_data;
    logic                   o_tx_valid;
    logic                   i_tx_ready;
    logic                   o_pipe_enable;
    logic                   i_halt;
    logic [NB_DATA-1:0]     i_pc;
    logic [NB_REG_ADDR-1:0] o_reg_addr;
    logic [NB_DATA-1:0]     i_reg_data;
    logic                   o_busy;

    modport slave (
        input  i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_pc, i_reg_data,
        output o_tx_data, o_tx_valid, o_pipe_enable, o_reg_addr, o_busy
    );

    modport master (
        output i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_pc, i_reg_data,
        input  o_tx_data, o_tx_valid, o_pipe_enable, o_reg_addr, o_busy
    );
endinterface

// File: rtl/debug_controller.sv
// Host debug sequencer for the pipelined RISC-V core: decodes command bytes, gates the
// pipeline, and streams the PC followed by x0..x[N_REGS-1] MSB-first over a byte handshake.
module debug_controller #(
    parameter int NB_DATA     = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int N_REGS      = 32,
    parameter int NB_BYTE     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    debug_controller_if.slave dbg
);

    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
    localparam int NB_BCNT        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int NB_WIDX        = $clog2(N_REGS + 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd1;
    localparam logic [2:0] ST_STEP = 3'd2;
    localparam logic [2:0] ST_LOAD = 3'd3;
    localparam logic [2:0] ST_SEND = 3'd4;

    localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h52);
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_DUMP = NB_BYTE'(8'h44);

    localparam logic [NB_BCNT-1:0]     LAST_BYTE = NB_BCNT'(BYTES_PER_WORD - 1);
    localparam logic [NB_WIDX-1:0]     LAST_WORD = NB_WIDX'(N_REGS);
    localparam logic [NB_WIDX-1:0]     WIDX_ZERO = {NB_WIDX{1'b0}};
    localparam logic [NB_REG_ADDR-1:0] ADDR_ZERO = {NB_REG_ADDR{1'b0}};

    logic [2:0]             state_q,    state_d;
    logic [NB_WIDX-1:0]     word_idx_q, word_idx_d;
    logic [NB_BCNT-1:0]     byte_cnt_q, byte_cnt_d;
    logic [NB_DATA-1:0]     shift_q,    shift_d;
    logic [NB_REG_ADDR-1:0] reg_addr_q, reg_addr_d;
    logic                   tx_fire_s;

    assign tx_fire_s = (state_q == ST_SEND) && dbg.i_tx_ready;

    // Next-state and datapath decode; the read address is set up on entry to LOAD.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        reg_addr_d = reg_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (dbg.i_rx_valid) begin
                    if (dbg.i_rx_data == CMD_RUN) begin
                        state_d = ST_RUN;
                    end else if (dbg.i_rx_data == CMD_STEP) begin
                        state_d = ST_STEP;
                    end else if (dbg.i_rx_data == CMD_DUMP) begin
                        state_d    = ST_LOAD;
                        word_idx_d = WIDX_ZERO;
                        reg_addr_d = ADDR_ZERO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (dbg.i_halt) begin
                    state_d    = ST_LOAD;
                    word_idx_d = WIDX_ZERO;
                    reg_addr_d = ADDR_ZERO;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                state_d    = ST_LOAD;
                word_idx_d = WIDX_ZERO;
                reg_addr_d = ADDR_ZERO;
            end
            ST_LOAD: begin
                shift_d    = (word_idx_q == WIDX_ZERO) ? dbg.i_pc : dbg.i_reg_data;
                byte_cnt_d = {NB_BCNT{1'b0}};
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (tx_fire_s) begin
                    shift_d    = shift_q << NB_BYTE;
                    byte_cnt_d = byte_cnt_q + NB_BCNT'(1);
                    if (byte_cnt_q == LAST_BYTE) begin
                        if (word_idx_q == LAST_WORD) begin
                            state_d = ST_IDLE;
                        end else begin
                            // Word k (k>=1) reads register k-1, i.e. the index before the increment.
                            word_idx_d = word_idx_q + NB_WIDX'(1);
                            reg_addr_d = NB_REG_ADDR'(word_idx_q);
                            state_d    = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset discards any partly sent word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            word_idx_q <= WIDX_ZERO;
            byte_cnt_q <= {NB_BCNT{1'b0}};
            shift_q    <= {NB_DATA{1'b0}};
            reg_addr_q <= ADDR_ZERO;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            reg_addr_q <= reg_addr_d;
        end
    end

    assign dbg.o_tx_valid    = (state_q == ST_SEND);
    assign dbg.o_tx_data     = shift_q[NB_DATA-1 -: NB_BYTE];
    assign dbg.o_pipe_enable = (state_q == ST_STEP) | ((state_q == ST_RUN) & ~dbg.i_halt);
    assign dbg.o_busy        = (state_q != ST_IDLE);
    assign dbg.o_reg_addr    = reg_addr_q;

endmodule
